// File: rtl/cache_tag_unit.sv
// Tag store and lookup controller for a 1/2-way cache: hit/miss detection,
// single-outstanding refill handshake and line-by-line invalidation sweep.
module cache_tag_unit #(
    parameter int ADDR_W   = 16,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 5,
    parameter int WAYS     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic                  resp_way,
    output logic [INDEX_W-1:0]    resp_index,
    output logic [OFFSET_W-3:0]   resp_word,
    output logic                  refill_req,
    output logic [ADDR_W-1:0]     refill_addr,
    input  logic                  refill_done,
    input  logic                  flush,
    output logic                  busy
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {ST_FLUSH, ST_IDLE, ST_LOOKUP, ST_REFILL} state_t;
    state_t state_reg, state_next;

    logic [ADDR_W-1:0]  addr_reg;
    logic [TAG_W-1:0]   tag_req;
    logic [INDEX_W-1:0] index_req;
    logic [INDEX_W-1:0] flush_cnt_reg;
    logic               flush_pend_reg;
    logic [LINES-1:0]   lru_reg;
    logic               victim_reg;
    logic [WAYS-1:0]    way_valid;
    logic [WAYS-1:0]    way_match;
    logic               accept;
    logic               hit;
    logic               hit_way;
    logic               miss_victim;
    logic               tag_we;
    logic               unused_addr_bits;

    assign tag_req          = addr_reg[ADDR_W-1 -: TAG_W];
    assign index_req        = addr_reg[OFFSET_W +: INDEX_W];
    assign unused_addr_bits = ^addr_reg[1:0];
    assign accept           = req_valid && req_ready;
    assign tag_we           = (state_reg == ST_REFILL) && refill_done && !rst;

    // Tag RAM read is launched at the handshake edge so LOOKUP compares a registered value.
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic [TAG_W-1:0] tag_mem [LINES];
            logic [TAG_W-1:0] tag_rd_reg;
            logic [LINES-1:0] valid_reg;

            always_ff @(posedge clk) begin
                if (tag_we && victim_reg == 1'(gi))
                    tag_mem[index_req] <= tag_req;
                if (accept)
                    tag_rd_reg <= tag_mem[req_addr[OFFSET_W +: INDEX_W]];
            end

            always_ff @(posedge clk) begin
                if (state_reg == ST_FLUSH)
                    valid_reg[flush_cnt_reg] <= 1'b0;
                else if (tag_we && victim_reg == 1'(gi))
                    valid_reg[index_req] <= 1'b1;
            end

            assign way_valid[gi] = valid_reg[index_req];
            assign way_match[gi] = valid_reg[index_req] && (tag_rd_reg == tag_req);
        end
    endgenerate

    assign hit = |way_match;

    always_comb begin
        hit_way     = 1'b0;
        miss_victim = 1'b0;
        if (WAYS > 1) begin
            hit_way = way_match[WAYS-1];
            if (!way_valid[0])
                miss_victim = 1'b0;
            else if (!way_valid[WAYS-1])
                miss_victim = 1'b1;
            else
                miss_victim = lru_reg[index_req];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= ST_FLUSH;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FLUSH:  if (flush_cnt_reg == '1) state_next = ST_IDLE;
            ST_IDLE: begin
                if (flush_pend_reg)
                    state_next = ST_FLUSH;
                else if (req_valid)
                    state_next = ST_LOOKUP;
            end
            ST_LOOKUP: state_next = hit ? ST_IDLE : ST_REFILL;
            ST_REFILL: if (refill_done) state_next = ST_IDLE;
            default:   state_next = ST_FLUSH;
        endcase
    end

    always_comb begin
        req_ready   = (state_reg == ST_IDLE) && !flush_pend_reg;
        busy        = (state_reg != ST_IDLE);
        refill_req  = (state_reg == ST_REFILL);
        refill_addr = {tag_req, index_req, {OFFSET_W{1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg       <= '0;
            flush_cnt_reg  <= '0;
            flush_pend_reg <= 1'b0;
            victim_reg     <= 1'b0;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_way       <= 1'b0;
            resp_index     <= '0;
            resp_word      <= '0;
        end else begin
            resp_valid <= 1'b0;
            if (state_reg == ST_FLUSH)
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            // Entering FLUSH consumes the pending request even if flush is high again.
            if (state_reg == ST_IDLE && flush_pend_reg)
                flush_pend_reg <= 1'b0;
            else if (flush && state_reg != ST_FLUSH)
                flush_pend_reg <= 1'b1;
            if (accept)
                addr_reg <= req_addr;
            if (state_reg == ST_LOOKUP) begin
                if (hit) begin
                    resp_valid <= 1'b1;
                    resp_hit   <= 1'b1;
                    resp_way   <= hit_way;
                    resp_index <= index_req;
                    resp_word  <= addr_reg[OFFSET_W-1:2];
                end else begin
                    victim_reg <= miss_victim;
                end
            end
            if (state_reg == ST_REFILL && refill_done) begin
                resp_valid <= 1'b1;
                resp_hit   <= 1'b0;
                resp_way   <= victim_reg;
                resp_index <= index_req;
                resp_word  <= addr_reg[OFFSET_W-1:2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == ST_FLUSH)
            lru_reg[flush_cnt_reg] <= 1'b0;
        else if (state_reg == ST_LOOKUP && hit)
            lru_reg[index_req] <= ~hit_way;
        else if (tag_we)
            lru_reg[index_req] <= ~victim_reg;
    end
endmodule

// File: tb/tb_cache_tag_unit.sv
// Bench for cache_tag_unit: directed scenarios plus randomized accesses
// checked against an array-based model of the 2-way tag store.
module tb_cache_tag_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = '0;
    logic        resp_valid, resp_hit, resp_way;
    logic [4:0]  resp_index;
    logic [2:0]  resp_word;
    logic        refill_req;
    logic [15:0] refill_addr;
    logic        refill_done = 1'b0;
    logic        flush = 1'b0;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: per way per line a valid flag and a tag, plus the way to evict next.
    bit         mv   [2][32];
    logic [5:0] mt   [2][32];
    bit         mlru [32];

    always #5 clk = ~clk;

    cache_tag_unit #(.ADDR_W(16), .INDEX_W(5), .OFFSET_W(5), .WAYS(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_way(resp_way), .resp_index(resp_index), .resp_word(resp_word),
        .refill_req(refill_req), .refill_addr(refill_addr),
        .refill_done(refill_done), .flush(flush), .busy(busy)
    );

    task automatic model_clear();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 32; i++) mv[w][i] = 1'b0;
        for (int i = 0; i < 32; i++) mlru[i] = 1'b0;
    endtask

    task automatic model_access(input logic [15:0] a, output bit eh, output bit ew);
        int idx;
        logic [5:0] tg;
        idx = int'(a[9:5]);
        tg  = a[15:10];
        eh = 1'b0;
        ew = 1'b0;
        for (int w = 0; w < 2; w++)
            if (!eh && mv[w][idx] && mt[w][idx] == tg) begin
                eh = 1'b1;
                ew = w[0];
            end
        if (!eh) begin
            if (!mv[0][idx])      ew = 1'b0;
            else if (!mv[1][idx]) ew = 1'b1;
            else                  ew = mlru[idx];
            mv[ew][idx] = 1'b1;
            mt[ew][idx] = tg;
        end
        mlru[idx] = ~ew;
    endtask

    // Drives one request; returns what the DUT showed. Latency counts cycles after acceptance.
    task automatic access(input logic [15:0] a, input int dly,
                          output logic o_hit, output logic o_way, output logic [4:0] o_idx,
                          output logic [2:0] o_word, output logic [15:0] o_raddr,
                          output int o_lat, output bit o_to, output logic o_rdy,
                          output logic o_rreq);
        int n, rc;
        o_to = 1'b0; o_raddr = '0; o_lat = 0;
        o_hit = 1'bx; o_way = 1'bx; o_idx = 'x; o_word = 'x; o_rdy = 1'bx; o_rreq = 1'bx;
        req_addr  = a;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            o_to = 1'b1;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        rc = 0;
        while (n < 300 && !resp_valid) begin
            if (refill_req) begin
                o_raddr = refill_addr;
                if (rc == dly) refill_done = 1'b1;
                rc++;
            end
            @(negedge clk);
            refill_done = 1'b0;
            n++;
        end
        o_lat = n;
        if (!resp_valid) begin
            o_to = 1'b1;
            return;
        end
        o_hit = resp_hit; o_way = resp_way; o_idx = resp_index; o_word = resp_word;
        o_rdy = req_ready; o_rreq = refill_req;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b0 || busy !== 1'b1 || resp_valid !== 1'b0 || refill_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: ready=%b busy=%b rv=%b rreq=%b, want 0 1 0 0",
                     req_ready, busy, resp_valid, refill_req);
        end
        tests_run++;
        if (resp_hit !== 1'b0 || resp_way !== 1'b0 || resp_index !== 5'd0 || resp_word !== 3'd0
            || refill_addr !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_fields: hit=%b way=%b idx=%h word=%h raddr=%h, want all 0",
                     resp_hit, resp_way, resp_index, resp_word, refill_addr);
        end
        rst = 1'b0;
        n = 0;
        while (!req_ready && busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n !== 32 || req_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flush_len: busy cycles=%0d ready=%b busy=%b, want 32 1 0",
                     n, req_ready, busy);
        end
        model_clear();
    endtask

    task automatic test_cold_miss_hit();
        logic h, w, rdy, rr; logic [4:0] ix; logic [2:0] wd; logic [15:0] ra;
        int lat; bit to, eh, ew;
        model_access(16'h1234, eh, ew);
        access(16'h1234, 3, h, w, ix, wd, ra, lat, to, rdy, rr);
        tests_run++;
        if (to || h !== eh || w !== ew || ra !== 16'h1220 || lat !== 6 || rr !== 1'b0) begin
            tests_failed++;
            $display("FAIL cold_miss: to=%0d hit=%b way=%b raddr=%h lat=%0d rreq=%b, want 0 %b %b 1220 6 0",
                     to, h, w, ra, lat, rr, eh, ew);
        end
        tests_run++;
        if (ix !== 5'h11 || wd !== 3'd5) begin
            tests_failed++;
            $display("FAIL cold_miss_fields: idx=%h word=%0d, want 11 5", ix, wd);
        end
        model_access(16'h1234, eh, ew);
        access(16'h1234, 0, h, w, ix, wd, ra, lat, to, rdy, rr);
        tests_run++;
        if (to || h !== eh || w !== ew || lat !== 2 || rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL repeat_hit: to=%0d hit=%b way=%b lat=%0d ready=%b, want 0 %b %b 2 1",
                     to, h, w, lat, rdy, eh, ew);
        end
        @(negedge clk);
        tests_run++;
        if (resp_valid !== 1'b0 || resp_hit !== 1'b1) begin
            tests_failed++;
            $display("FAIL resp_pulse: rv=%b hit=%b after response, want 0 1 (held)", resp_valid, resp_hit);
        end
    endtask

    task automatic test_conflict();
        logic [15:0] seq [4];
        logic h, w, rdy, rr; logic [4:0] ix; logic [2:0] wd; logic [15:0] ra;
        int lat; bit to, eh, ew;
        seq[0] = 16'h5634; seq[1] = 16'h9A34; seq[2] = 16'h5634; seq[3] = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            model_access(seq[i], eh, ew);
            access(seq[i], i, h, w, ix, wd, ra, lat, to, rdy, rr);
            tests_run++;
            if (to || h !== eh || w !== ew || (!eh && ra !== {seq[i][15:5], 5'd0})) begin
                tests_failed++;
                $display("FAIL conflict_%0d: addr=%h to=%0d hit=%b way=%b raddr=%h, want hit=%b way=%b",
                         i, seq[i], to, h, w, ra, eh, ew);
            end
        end
    endtask

    task automatic test_random();
        logic h, w, rdy, rr; logic [4:0] ix; logic [2:0] wd; logic [15:0] ra, a;
        logic [4:0] pidx [3];
        int lat, dly, bad, exp_lat; bit to, eh, ew;
        pidx[0] = 5'h03; pidx[1] = 5'h07; pidx[2] = 5'h11;
        bad = 0;
        for (int t = 0; t < 60; t++) begin
            a = {6'($urandom_range(0, 3)), pidx[$urandom_range(0, 2)], 5'($urandom)};
            dly = $urandom_range(0, 4);
            model_access(a, eh, ew);
            access(a, dly, h, w, ix, wd, ra, lat, to, rdy, rr);
            exp_lat = eh ? 2 : 3 + dly;
            if (to || h !== eh || w !== ew || ix !== a[9:5] || wd !== a[4:2] || lat !== exp_lat
                || (!eh && ra !== {a[15:5], 5'd0})) begin
                bad++;
                $display("FAIL random_%0d: addr=%h hit=%b way=%b idx=%h word=%h lat=%0d raddr=%h, want hit=%b way=%b lat=%0d",
                         t, a, h, w, ix, wd, lat, ra, eh, ew, exp_lat);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        tests_run++;
        if (bad !== 0) tests_failed++;
    endtask

    task automatic test_flush_idle();
        logic h, w, rdy, rr; logic [4:0] ix; logic [2:0] wd; logic [15:0] ra;
        int lat, n, bad; bit to, eh, ew;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b1;
        req_addr  = 16'h5634;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_pending_ready: ready=%b, want 0", req_ready);
        end
        @(negedge clk);
        n = 0; bad = 0;
        while (busy && n < 100) begin
            if (req_ready !== 1'b0 || resp_valid !== 1'b0) bad++;
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        tests_run++;
        if (n !== 32 || bad !== 0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_idle: busy cycles=%0d bad=%0d ready=%b, want 32 0 1", n, bad, req_ready);
        end
        model_clear();
        model_access(16'h5634, eh, ew);
        access(16'h5634, 1, h, w, ix, wd, ra, lat, to, rdy, rr);
        tests_run++;
        if (to || h !== eh || w !== ew) begin
            tests_failed++;
            $display("FAIL after_flush: to=%0d hit=%b way=%b, want hit=%b way=%b", to, h, w, eh, ew);
        end
    endtask

    task automatic test_flush_refill();
        int n, bad;
        req_addr  = 16'hFD44;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (refill_req !== 1'b1 || refill_addr !== 16'hFD40) begin
            tests_failed++;
            $display("FAIL fr_refill: rreq=%b raddr=%h, want 1 fd40", refill_req, refill_addr);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        refill_done = 1'b1;
        @(negedge clk);
        refill_done = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b1 || resp_hit !== 1'b0 || req_ready !== 1'b0 || refill_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL fr_resp: rv=%b hit=%b ready=%b rreq=%b, want 1 0 0 0",
                     resp_valid, resp_hit, req_ready, refill_req);
        end
        req_valid = 1'b1;
        req_addr  = 16'h1234;
        @(negedge clk);
        n = 0; bad = 0;
        while (busy && n < 100) begin
            if (req_ready !== 1'b0 || resp_valid !== 1'b0) bad++;
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        tests_run++;
        if (n !== 32 || bad !== 0) begin
            tests_failed++;
            $display("FAIL fr_flush: busy cycles=%0d bad=%0d, want 32 0", n, bad);
        end
        model_clear();
    endtask

    task automatic test_reset_refill();
        logic h, w, rdy, rr; logic [4:0] ix; logic [2:0] wd; logic [15:0] ra;
        int lat, n, bad; bit to, eh, ew;
        model_access(16'h1234, eh, ew);
        access(16'h1234, 0, h, w, ix, wd, ra, lat, to, rdy, rr);
        req_addr  = 16'h5634;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        refill_done = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        refill_done = 1'b0;
        tests_run++;
        if (refill_req !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_refill: rreq=%b rv=%b busy=%b, want 0 0 1", refill_req, resp_valid, busy);
        end
        rst = 1'b0;
        n = 0; bad = 0;
        while (!req_ready && n < 100) begin
            if (resp_valid !== 1'b0) bad++;
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n !== 32 || bad !== 0) begin
            tests_failed++;
            $display("FAIL rst_refill_flush: cycles=%0d resp pulses=%0d, want 32 0", n, bad);
        end
        model_clear();
        model_access(16'h1234, eh, ew);
        access(16'h1234, 2, h, w, ix, wd, ra, lat, to, rdy, rr);
        tests_run++;
        if (to || h !== eh || w !== ew || ra !== 16'h1220) begin
            tests_failed++;
            $display("FAIL rst_then_miss: to=%0d hit=%b way=%b raddr=%h, want hit=%b way=%b 1220",
                     to, h, w, ra, eh, ew);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss_hit();
        test_conflict();
        test_random();
        test_flush_idle();
        test_flush_refill();
        test_reset_refill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
